// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one spi_master between NREQ requesters.
// Round-robin pick in IDLE, one-cycle LAUNCH that triggers the master, RUN
// counts new_data rising edges and steers rx bytes / tx-advance strobes to the
// granted requester, DONE pulses completion (and timeout error) for one cycle.
module spi_bus_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                 sysclk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [3*NREQ-1:0]    req_ss,
   input  logic [16*NREQ-1:0]   req_len,
   input  logic [8*NREQ-1:0]    tx_data,
   output logic [NREQ-1:0]      grant,
   output logic [NREQ-1:0]      tx_next,
   output logic [7:0]           rx_data,
   output logic [NREQ-1:0]      rx_valid,
   output logic [NREQ-1:0]      done,
   output logic [NREQ-1:0]      err,
   output logic [2:0]           m_ss,
   output logic [7:0]           m_data_in,
   output logic [15:0]          m_how_many_bytes,
   output logic                 m_trigger,
   input  logic                 m_busy,
   input  logic                 m_new_data,
   input  logic [7:0]           m_data_out
);

   localparam int          IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

   state_t                 state;
   logic [IDX_W-1:0]       idx, rr_ptr, pick_idx, scan;
   logic                   pick_found;
   logic [15:0]            len_q, byte_cnt, tcnt, cnt_inc;
   logic                   nd_prev, nd_edge, busy_seen;

   // requester buses viewed as per-lane packed arrays
   logic [NREQ-1:0][2:0]   ss_arr;
   logic [NREQ-1:0][15:0]  len_arr;
   logic [NREQ-1:0][7:0]   tx_arr;

   assign ss_arr  = req_ss;
   assign len_arr = req_len;
   assign tx_arr  = tx_data;

   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NREQ) s = s - NREQ;
      return IDX_W'(s);
   endfunction

   function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
      logic [NREQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   assign nd_edge   = m_new_data & ~nd_prev;
   assign cnt_inc   = byte_cnt + 16'd1;
   // grant is zero outside a transaction, so this also yields 0 when idle
   assign m_data_in = (|grant) ? tx_arr[idx] : 8'h00;

   // round-robin scan: first set req bit starting at rr_ptr, wrapping
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan       = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan = wrap_add(rr_ptr, k);
         if (!pick_found && req[scan]) begin
            pick_found = 1'b1;
            pick_idx   = scan;
         end
      end
   end

   // transaction FSM with registered outputs; pulses default low each cycle
   always_ff @(posedge sysclk) begin
      if (rst) begin
         state            <= IDLE;
         idx              <= '0;
         rr_ptr           <= '0;
         len_q            <= '0;
         byte_cnt         <= '0;
         tcnt             <= '0;
         nd_prev          <= 1'b0;
         busy_seen        <= 1'b0;
         grant            <= '0;
         tx_next          <= '0;
         rx_valid         <= '0;
         done             <= '0;
         err              <= '0;
         rx_data          <= '0;
         m_ss             <= '0;
         m_how_many_bytes <= '0;
         m_trigger        <= 1'b0;
      end else begin
         nd_prev   <= m_new_data;
         m_trigger <= 1'b0;
         tx_next   <= '0;
         rx_valid  <= '0;
         done      <= '0;
         err       <= '0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  idx       <= pick_idx;
                  len_q     <= len_arr[pick_idx];
                  grant     <= onehot(pick_idx);
                  byte_cnt  <= '0;
                  tcnt      <= '0;
                  busy_seen <= 1'b0;
                  // master is only touched for a non-empty transfer
                  if (len_arr[pick_idx] != 16'd0) begin
                     m_trigger        <= 1'b1;
                     m_ss             <= ss_arr[pick_idx];
                     m_how_many_bytes <= len_arr[pick_idx];
                  end
                  state <= LAUNCH;
               end
            end
            LAUNCH: begin
               if (len_q == 16'd0) begin
                  done  <= grant;
                  state <= DONE;
               end else begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (m_busy) busy_seen <= 1'b1;
               if (nd_edge) begin
                  rx_data  <= m_data_out;
                  rx_valid <= grant;
                  tx_next  <= grant;
                  byte_cnt <= cnt_inc;
                  tcnt     <= '0;
               end else begin
                  tcnt <= tcnt + 16'd1;
               end
               // a master that finishes early is a normal completion; an edge
               // on the timeout boundary cancels the timeout
               if ((nd_edge && cnt_inc == len_q) || (busy_seen && !m_busy)) begin
                  done  <= grant;
                  state <= DONE;
               end else if (!nd_edge && tcnt == TO_LAST) begin
                  done  <= grant;
                  err   <= grant;
                  state <= DONE;
               end
            end
            DONE: begin
               grant            <= '0;
               m_ss             <= '0;
               m_how_many_bytes <= '0;
               rr_ptr           <= wrap_add(idx, 1);
               state            <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: a transaction-level reference model
// predicts grant order, master launches, rx bytes and completions; a negedge
// monitor pops and compares whenever the DUT presents one of them.
module tb_spi_bus_arbiter;

   localparam int NREQ = 4;

   typedef struct {
      bit              is_done;
      logic [NREQ-1:0] who;
      logic [7:0]      data;
      bit              er;
   } ev_t;

   typedef struct {
      int idx;
      int ss;
      int len;
   } trig_t;

   logic                 sysclk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req;
   logic [3*NREQ-1:0]    req_ss;
   logic [16*NREQ-1:0]   req_len;
   logic [8*NREQ-1:0]    tx_data;
   logic [NREQ-1:0]      grant, tx_next, rx_valid, done, err;
   logic [7:0]           rx_data, m_data_in, m_data_out;
   logic [2:0]           m_ss;
   logic [15:0]          m_how_many_bytes;
   logic                 m_trigger, m_busy, m_new_data;

   int checks = 0;
   int errors = 0;

   ev_t           exp_q[$];
   logic [NREQ-1:0] g_q[$];
   trig_t         t_q[$];
   logic [7:0]    mbyte_q[$];
   logic [7:0]    fixed_q[$];

   int          cfg_len[NREQ];
   int          cfg_ss[NREQ];
   logic [7:0]  tx_val[NREQ];
   int          rr;
   int          m_limit, m_hang;
   int          m_act, m_left, m_tmr;
   logic [NREQ-1:0] gprev;
   int          gcur, glast, trig_cnt, t_trig, t_done, cyc;

   spi_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(16)) dut (
      .sysclk(sysclk), .rst(rst), .req(req), .req_ss(req_ss), .req_len(req_len),
      .tx_data(tx_data), .grant(grant), .tx_next(tx_next), .rx_data(rx_data),
      .rx_valid(rx_valid), .done(done), .err(err), .m_ss(m_ss),
      .m_data_in(m_data_in), .m_how_many_bytes(m_how_many_bytes),
      .m_trigger(m_trigger), .m_busy(m_busy), .m_new_data(m_new_data),
      .m_data_out(m_data_out)
   );

   always #5 sysclk = ~sysclk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // spi_master stand-in: on trigger, raises busy, emits one new_data pulse
   // every 5 cycles with bytes from mbyte_q, then drops busy
   always @(negedge sysclk) begin
      if (rst) begin
         m_busy = 1'b0; m_new_data = 1'b0; m_act = 0;
      end else begin
         m_new_data = 1'b0;
         if (m_trigger && m_hang == 0) begin
            m_act = 1; m_busy = 1'b1; m_tmr = 4;
            m_left = (int'(m_how_many_bytes) < m_limit) ? int'(m_how_many_bytes) : m_limit;
         end else if (m_act != 0) begin
            if (m_tmr > 0) m_tmr--;
            else if (m_left > 0) begin
               m_data_out = (mbyte_q.size() > 0) ? mbyte_q.pop_front() : 8'h00;
               m_new_data = 1'b1; m_left--; m_tmr = 4;
            end else begin
               m_busy = 1'b0; m_act = 0;
            end
         end
      end
   end

   // monitor / scoreboard
   always @(negedge sysclk) begin
      ev_t   e;
      trig_t t;
      cyc++;
      if (!rst) begin
         chk("grant_onehot", 64'($countones(grant) <= 1), 64'd1);
         chk("outs_only_to_granted", 64'((tx_next | rx_valid | done | err) & ~grant), 64'd0);
         if (gprev != '0 && grant != '0) chk("grant_no_direct_switch", 64'(grant), 64'(gprev));
         if (grant != '0 && gprev == '0) begin
            chk("grant_expected", 64'(g_q.size() > 0), 64'd1);
            if (g_q.size() > 0) chk("grant_order", 64'(grant), 64'(g_q.pop_front()));
         end
         if (m_trigger) begin
            trig_cnt++; t_trig = cyc;
            chk("trigger_expected", 64'(t_q.size() > 0), 64'd1);
            if (t_q.size() > 0) begin
               t = t_q.pop_front();
               chk("m_ss", 64'(m_ss), 64'(t.ss));
               chk("m_how_many_bytes", 64'(m_how_many_bytes), 64'(t.len));
               chk("m_data_in", 64'(m_data_in), 64'(tx_val[t.idx]));
            end
         end
         if (rx_valid != '0) begin
            chk("rx_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("rx_valid", 64'(rx_valid), e.is_done ? 64'd0 : 64'(e.who));
               chk("tx_next", 64'(tx_next), e.is_done ? 64'd0 : 64'(e.who));
               chk("rx_data", 64'(rx_data), 64'(e.data));
            end
         end
         if (done != '0) begin
            t_done = cyc;
            chk("done_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("done", 64'(done), e.is_done ? 64'(e.who) : 64'd0);
               chk("err", 64'(err), e.er ? 64'(e.who) : 64'd0);
            end
         end
      end
      if (grant != '0) gcur++;
      else if (gprev != '0) begin glast = gcur; gcur = 0; end
      gprev = grant;
   end

   // reference model: predicts arbitration order and responses for a batch
   task automatic gen(input logic [NREQ-1:0] mask, input int limit, input int hang, input int held);
      logic [NREQ-1:0] m, oh;
      int p, i, n, nb;
      ev_t e;
      trig_t t;
      logic [7:0] b;
      m = mask; p = rr;
      n = (held > 0) ? held : $countones(mask);
      for (int k = 0; k < n; k++) begin
         i = p;
         while (!m[i]) i = (i + 1) % NREQ;
         oh = '0; oh[i] = 1'b1;
         g_q.push_back(oh);
         if (cfg_len[i] > 0) begin
            t.idx = i; t.ss = cfg_ss[i]; t.len = cfg_len[i];
            t_q.push_back(t);
         end
         nb = (hang != 0) ? 0 : ((cfg_len[i] < limit) ? cfg_len[i] : limit);
         for (int j = 0; j < nb; j++) begin
            b = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom);
            mbyte_q.push_back(b);
            e = '{1'b0, oh, b, 1'b0};
            exp_q.push_back(e);
         end
         e = '{1'b1, oh, 8'h00, (hang != 0 && cfg_len[i] > 0)};
         exp_q.push_back(e);
         if (held == 0) m[i] = 1'b0;
         p = (i + 1) % NREQ;
      end
      rr = p;
      for (int q = 0; q < NREQ; q++) begin
         req_ss[3*q +: 3]   = 3'(cfg_ss[q]);
         req_len[16*q +: 16] = 16'(cfg_len[q]);
      end
      m_limit = limit; m_hang = hang;
      req = mask;
   endtask

   // advance until all predictions are consumed; requesters drop req on done
   task automatic run(input int budget, input bit drop, input int stop_n);
      int n = 0;
      int c = 0;
      while (c < budget) begin
         @(negedge sysclk); c++;
         if (done != '0) begin
            n++;
            if (drop) req = req & ~done;
            if (stop_n > 0 && n >= stop_n) req = '0;
         end
         if (exp_q.size() == 0 && g_q.size() == 0 && t_q.size() == 0) break;
      end
      chk("run_within_budget", 64'(c < budget), 64'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   // reset asserted from the current negedge for two clock edges
   task automatic do_reset();
      rst = 1'b1; req = '0;
      @(negedge sysclk);
      chk("reset_req_outs", 64'({grant, tx_next, rx_valid, done, err}), 64'd0);
      chk("reset_master_outs", 64'({m_ss, m_how_many_bytes, m_trigger, m_data_in, rx_data}), 64'd0);
      @(negedge sysclk);
      rst = 1'b0; rr = 0;
      chk("reset_pending_predictions", 64'(exp_q.size() + g_q.size() + t_q.size()), 64'd0);
      exp_q.delete(); g_q.delete(); t_q.delete(); mbyte_q.delete();
   endtask

   initial begin
      int tc;
      rst = 1'b1; req = '0; req_ss = '0; req_len = '0;
      m_limit = 100; m_hang = 0; rr = 0; gprev = '0;
      gcur = 0; glast = 0; trig_cnt = 0; t_trig = 0; t_done = 0; cyc = 0;
      for (int i = 0; i < NREQ; i++) begin
         tx_val[i] = 8'($urandom);
         tx_data[8*i +: 8] = tx_val[i];
         cfg_len[i] = 1; cfg_ss[i] = i;
      end
      idle(2);
      do_reset();
      idle(2);

      // single request with fixed master bytes
      cfg_len[0] = 3; cfg_ss[0] = 2;
      fixed_q = '{8'hA5, 8'h3C, 8'hFF};
      gen(4'b0001, 100, 0, 0); run(300, 1'b1, 0); idle(8);

      // round robin, all requesting and holding req, len 1 each
      @(negedge sysclk); do_reset();
      for (int i = 0; i < NREQ; i++) cfg_len[i] = 1;
      gen(4'b1111, 100, 0, 5); run(400, 1'b0, 5); idle(8);

      // zero length
      cfg_len[2] = 0; tc = trig_cnt;
      gen(4'b0100, 100, 0, 0); run(100, 1'b1, 0); idle(8);
      chk("zero_len_grant_cycles", 64'(glast), 64'd2);
      chk("zero_len_no_trigger", 64'(trig_cnt - tc), 64'd0);

      // timeout on requester 1, then rr continues from 2
      cfg_len[1] = 3; cfg_ss[1] = 5;
      gen(4'b0010, 100, 1, 0); run(100, 1'b1, 0); idle(8);
      chk("timeout_latency", 64'(t_done - t_trig), 64'd17);
      cfg_len[0] = 2; cfg_len[2] = 2;
      gen(4'b0101, 100, 0, 0); run(300, 1'b1, 0); idle(8);

      // early busy drop, including a maximal length
      cfg_len[0] = 5;
      gen(4'b0001, 2, 0, 0); run(300, 1'b1, 0); idle(8);
      cfg_len[3] = 65535; cfg_ss[3] = 7;
      gen(4'b1000, 3, 0, 0); run(300, 1'b1, 0); idle(8);

      // reset mid-RUN after the first of four bytes
      cfg_len[0] = 4;
      gen(4'b0001, 100, 0, 0);
      exp_q = exp_q[0:0];
      run(100, 1'b1, 0);
      do_reset(); idle(12);
      cfg_len[0] = 1; cfg_len[3] = 1;
      gen(4'b1001, 100, 0, 0); run(300, 1'b1, 0); idle(8);

      // randomized batches
      for (int b = 0; b < 6; b++) begin
         for (int i = 0; i < NREQ; i++) begin
            cfg_len[i] = $urandom_range(1, 4);
            cfg_ss[i]  = $urandom_range(0, 7);
         end
         gen(4'($urandom_range(1, 15)), 100, 0, 0);
         run(1000, 1'b1, 0); idle(8);
      end

      chk("final_pending_predictions", 64'(exp_q.size() + g_q.size() + t_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
